// File: rtl/serial_sum_collector.sv
// -----------------------------------------------------------------------------
// serial_sum_collector
//
// Collects the LSB-first serial sum stream of the bit-serial adder together
// with its final carry, and presents each completed frame as the parallel
// word {out_cout, out_sum} on a valid/ready port.
//
// The design is double-buffered. The shift register assembles the next frame
// while the output register holds the current one. When a frame completes
// while the output is still occupied, the shift register (plus a one-bit carry
// hold) keeps the word and the collector stops accepting beats (FULL) until
// the consumer drains.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   in_valid   : serial beat strobe from the adder
//   in_ready   : collector can accept a beat (high in COLLECT)
//   in_bit     : sum bit, LSB first
//   in_last    : marks the final (MSB) beat of a frame
//   in_cout    : carry-out, sampled only on the in_last beat
//   out_valid  : out_sum/out_cout hold a complete frame
//   out_ready  : consumer accepts the word
//   out_sum    : assembled WIDTH-bit sum
//   out_cout   : frame carry-out
//   frame_err  : sticky framing-error flag (early or missing in_last)
//   err_clr    : synchronous clear of frame_err; a new error in the same
//                cycle wins
// -----------------------------------------------------------------------------
module serial_sum_collector #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             frame_err,
  input  logic             err_clr
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] sr_q,        sr_d;
  logic             hold_cout_q, hold_cout_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q,   out_sum_d;
  logic             out_cout_q,  out_cout_d;
  logic             frame_err_q, frame_err_d;

  logic             beat;
  logic             drain;
  logic [WIDTH-1:0] word;

  assign in_ready  = (state_q == ST_COLLECT);
  assign beat      = in_valid & in_ready;
  assign drain     = out_valid_q & out_ready;
  // Word as it stands after shifting in the current bit.
  assign word      = {in_bit, sr_q[WIDTH-1:1]};

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    hold_cout_d = hold_cout_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    frame_err_d = frame_err_q;

    // Clear first so that an error detected below in the same cycle wins.
    if (err_clr) begin
      frame_err_d = 1'b0;
    end

    // A drain with no replacement word empties the output; data is kept.
    if (drain) begin
      out_valid_d = 1'b0;
    end

    if (state_q == ST_COLLECT) begin
      if (beat) begin
        sr_d = word;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (in_last) begin
            if (!out_valid_q || drain) begin
              out_sum_d   = word;
              out_cout_d  = in_cout;
              out_valid_d = 1'b1;
            end else begin
              // Output still occupied: park the word in sr and stall.
              hold_cout_d = in_cout;
              state_d     = ST_FULL;
            end
          end else begin
            // Missing last: drop the word and resync on the next beat.
            frame_err_d = 1'b1;
          end
        end else begin
          if (in_last) begin
            // Early last: drop the partial frame.
            cnt_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end else begin
      // FULL: the parked word moves to the output on the draining edge.
      if (drain) begin
        out_sum_d   = sr_q;
        out_cout_d  = hold_cout_q;
        out_valid_d = 1'b1;
        state_d     = ST_COLLECT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      sr_q        <= '0;
      hold_cout_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      hold_cout_q <= hold_cout_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_serial_sum_collector.sv
// -----------------------------------------------------------------------------
// tb_serial_sum_collector
//
// Directed bench for serial_sum_collector with WIDTH=4. A table of frames
// with hand-computed {cout, sum} words is streamed at full rate, followed by
// hand-written sequences for backpressure, framing errors and async reset.
// -----------------------------------------------------------------------------
module tb_serial_sum_collector;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_last;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             frame_err;
  logic             err_clr;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [3:0] bits;
    logic       cout;
    logic [4:0] exp_word;
  } vec_t;

  vec_t tbl[6];

  serial_sum_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b, input logic last, input logic c);
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    in_cout  = c;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bit   = 1'b0;
    in_cout  = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] bits, input logic c);
    for (int i = 0; i < 4; i++) begin
      beat(bits[i], (i == 3), c);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    in_cout   = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;

    tbl[0] = '{bits: 4'h5, cout: 1'b0, exp_word: 5'h05};
    tbl[1] = '{bits: 4'hA, cout: 1'b1, exp_word: 5'h1A};
    tbl[2] = '{bits: 4'hF, cout: 1'b1, exp_word: 5'h1F};
    tbl[3] = '{bits: 4'h0, cout: 1'b0, exp_word: 5'h00};
    tbl[4] = '{bits: 4'h8, cout: 1'b0, exp_word: 5'h08};
    tbl[5] = '{bits: 4'h1, cout: 1'b1, exp_word: 5'h11};

    // Reset state and release
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum",   {28'd0, out_sum},   32'd0);
    chk("rst_out_cout",  {31'd0, out_cout},  32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Test 1: beats 1,0,1,0 with cout=1
    send_frame(4'b0101, 1'b1);
    chk("t1_valid",     {31'd0, out_valid}, 32'd1);
    chk("t1_sum",       {28'd0, out_sum},   32'h5);
    chk("t1_cout",      {31'd0, out_cout},  32'd1);
    chk("t1_frame_err", {31'd0, frame_err}, 32'd0);
    tick();
    chk("t1_valid_1cyc", {31'd0, out_valid}, 32'd0);
    chk("t1_sum_held",   {28'd0, out_sum},   32'h5);

    // Table-driven frames at full rate
    for (int v = 0; v < 6; v++) begin
      send_frame(tbl[v].bits, tbl[v].cout);
      chk($sformatf("tbl%0d_valid", v), {31'd0, out_valid}, 32'd1);
      chk($sformatf("tbl%0d_word", v), {27'd0, out_cout, out_sum}, {27'd0, tbl[v].exp_word});
    end
    tick();
    chk("tbl_drained", {31'd0, out_valid}, 32'd0);

    // Test 2: two frames back-to-back, in_ready must stay high
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t2_in_ready_f%0d_b%0d", f, i), {31'd0, in_ready}, 32'd1);
        beat((f == 0) ? (i == 1) : (i != 1), (i == 3), 1'b0);
        if (f == 1 && i == 0) begin
          chk("t2_pulse_gap", {31'd0, out_valid}, 32'd0);
        end
      end
      chk($sformatf("t2_valid_f%0d", f), {31'd0, out_valid}, 32'd1);
      chk($sformatf("t2_sum_f%0d", f), {28'd0, out_sum}, (f == 0) ? 32'h2 : 32'hD);
    end
    tick();
    chk("t2_drained", {31'd0, out_valid}, 32'd0);

    // Test 3: backpressure, A held, B parked, stray beat ignored
    out_ready = 1'b0;
    send_frame(4'hA, 1'b0);
    chk("t3_valid_a", {31'd0, out_valid}, 32'd1);
    chk("t3_sum_a",   {28'd0, out_sum},   32'hA);
    send_frame(4'h3, 1'b1);
    chk("t3_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("t3_sum_still_a",   {28'd0, out_sum},  32'hA);
    chk("t3_cout_still_a",  {31'd0, out_cout}, 32'd0);
    beat(1'b1, 1'b1, 1'b1);
    chk("t3_ignored_err",   {31'd0, frame_err}, 32'd0);
    chk("t3_ignored_sum",   {28'd0, out_sum},   32'hA);
    out_ready = 1'b1;
    tick();
    chk("t3_sum_b",      {28'd0, out_sum},   32'h3);
    chk("t3_cout_b",     {31'd0, out_cout},  32'd1);
    chk("t3_valid_b",    {31'd0, out_valid}, 32'd1);
    chk("t3_in_ready_b", {31'd0, in_ready},  32'd1);
    tick();
    chk("t3_drained", {31'd0, out_valid}, 32'd0);

    // Test 4: early last, then good frame, then err_clr and set-wins
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    chk("t4_err",      {31'd0, frame_err}, 32'd1);
    chk("t4_no_valid", {31'd0, out_valid}, 32'd0);
    send_frame(4'hF, 1'b0);
    chk("t4_valid_f", {31'd0, out_valid}, 32'd1);
    chk("t4_word_f",  {27'd0, out_cout, out_sum}, 32'h0F);
    chk("t4_err_sticky", {31'd0, frame_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    chk("t4_err_clr", {31'd0, frame_err}, 32'd0);
    beat(1'b1, 1'b1, 1'b0);
    chk("t4_set_wins", {31'd0, frame_err}, 32'd1);
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr2", {31'd0, frame_err}, 32'd0);

    // Test 5: missing last, then resynced frame
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 1'b0, 1'b1);
    end
    chk("t5_err",      {31'd0, frame_err}, 32'd1);
    chk("t5_no_valid", {31'd0, out_valid}, 32'd0);
    send_frame(4'h6, 1'b1);
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_word",  {27'd0, out_cout, out_sum}, 32'h16);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_err_clr", {31'd0, frame_err}, 32'd0);

    // Test 6: async reset mid-frame with a word waiting
    out_ready = 1'b0;
    send_frame(4'h9, 1'b0);
    chk("t6_valid_pre", {31'd0, out_valid}, 32'd1);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_sum",   {28'd0, out_sum},   32'h0);
    chk("t6_in_ready",    {31'd0, in_ready},  32'd1);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    send_frame(4'hC, 1'b1);
    chk("t6_valid_post", {31'd0, out_valid}, 32'd1);
    chk("t6_word_post",  {27'd0, out_cout, out_sum}, 32'h1C);
    chk("t6_err_post",   {31'd0, frame_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
